// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
//
// Exhaustive stimulus engine for a combinational block. After a start pulse it
// walks every one of the 2^N_IN input vectors, holds each for HOLD clocks and,
// on the last clock of each hold, compares the M_CH DUT outputs against the
// EXPECTED truth table. It reports the number of failing vectors and the first
// failing vector.
//
// Optional build macro:
//   SWEEP_GRAY_EN - drive vectors in reflected Gray order (one input toggles
//                   per step) instead of plain binary order.
//
// Ports:
//   clk             in   rising-edge clock
//   reset           in   synchronous, active-high
//   start           in   begin a sweep (only honoured in IDLE or DONE)
//   vec_out         out  N_IN   vector driven to the DUT inputs
//   dut_in          in   M_CH   DUT outputs sampled by this block
//   busy            out  high while sweeping
//   done            out  high in DONE until the next start or reset
//   pass            out  done and no failing vector
//   err_count       out  N_IN+1 number of vectors with any channel mismatch
//   first_err_vec   out  N_IN   vector value of the first mismatch
//   first_err_valid out  first_err_vec holds a captured value
// -----------------------------------------------------------------------------
module truth_table_sweeper #(
    parameter int N_IN = 5,
    parameter int M_CH = 2,
    parameter int HOLD = 10,
    parameter logic [M_CH*(2**N_IN)-1:0] EXPECTED = {32'hFFFF_FFFE, 32'h8000_0000}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [N_IN-1:0]   vec_out,
    input  logic [M_CH-1:0]   dut_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   first_err_vec,
    output logic              first_err_valid
);

    localparam int NV    = 2**N_IN;
    localparam int EXP_W = M_CH * NV;
    localparam int IDX_W = $clog2(EXP_W);
    localparam int HC_W  = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N_IN-1:0]   r_ord;          // ordinal of the current vector, 0..2^N_IN-1
    logic [HC_W-1:0]   r_hold_cnt;
    logic [N_IN:0]     r_err_cnt;
    logic [N_IN-1:0]   r_first_vec;
    logic              r_first_valid;

    logic [N_IN-1:0]   w_vec;
    logic [M_CH-1:0]   w_exp;
    logic              w_mismatch;
    logic              w_hold_last;
    logic              w_ord_last;
    logic              w_sample;
    logic              w_launch;

    // The ordinal always counts in binary; only the driven value is re-coded,
    // so the end-of-sweep test is identical in both orders.
`ifdef SWEEP_GRAY_EN
    assign w_vec = r_ord ^ (r_ord >> 1);
`else
    assign w_vec = r_ord;
`endif

    // Truth-table lookup for the vector actually driven on vec_out.
    always_comb begin
        logic [IDX_W-1:0] idx;
        idx   = '0;
        w_exp = '0;
        for (int ch = 0; ch < M_CH; ch++) begin
            idx       = IDX_W'(ch * NV) + IDX_W'(w_vec);
            w_exp[ch] = EXPECTED[idx];
        end
    end

    assign w_mismatch  = |(dut_in ^ w_exp);
    assign w_hold_last = (r_hold_cnt == HC_W'(HOLD - 1));
    assign w_ord_last  = (r_ord == {N_IN{1'b1}});
    assign w_sample    = (r_state == S_RUN) && w_hold_last;
    assign w_launch    = (r_state != S_RUN) && start;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_sample && w_ord_last) w_state_nxt = S_DONE;
            S_DONE:  if (start) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ord         <= '0;
            r_hold_cnt    <= '0;
            r_err_cnt     <= '0;
            r_first_vec   <= '0;
            r_first_valid <= 1'b0;
        end else if (w_launch) begin
            r_ord         <= '0;
            r_hold_cnt    <= '0;
            r_err_cnt     <= '0;
            r_first_vec   <= '0;
            r_first_valid <= 1'b0;
        end else if (r_state == S_RUN) begin
            if (w_hold_last) begin
                r_hold_cnt <= '0;
                r_err_cnt  <= r_err_cnt + {{N_IN{1'b0}}, w_mismatch};
                if (w_mismatch && !r_first_valid) begin
                    r_first_vec   <= w_vec;
                    r_first_valid <= 1'b1;
                end
                // The last vector stays on vec_out through DONE.
                if (!w_ord_last) begin
                    r_ord <= r_ord + 1'b1;
                end
            end else begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    assign vec_out         = w_vec;
    assign busy            = (r_state == S_RUN);
    assign done            = (r_state == S_DONE);
    assign pass            = (r_state == S_DONE) && (r_err_cnt == '0);
    assign err_count       = r_err_cnt;
    assign first_err_vec   = r_first_vec;
    assign first_err_valid = r_first_valid;

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       reset;
    logic       start0;
    logic       start4;
    logic       stuck;

    // Default configuration: N_IN=5, M_CH=2, HOLD=10 (AND5 / OR5 table)
    logic [4:0] vec0;
    logic [1:0] din0;
    logic       busy0, done0, pass0, fval0;
    logic [5:0] err0;
    logic [4:0] fvec0;

    // Small configuration: N_IN=3, M_CH=1, HOLD=1, EXPECTED=8'h80
    logic [2:0] vec4;
    logic       busy4, done4, pass4, fval4;
    logic [3:0] err4;
    logic [2:0] fvec4;

    always #5 clk = ~clk;

    // Modelled DUT: ch0 = AND5, ch1 = OR5 (optionally stuck at 0)
    assign din0[0] = &vec0;
    assign din0[1] = stuck ? 1'b0 : |vec0;

    truth_table_sweeper u_dut0 (
        .clk(clk), .reset(reset), .start(start0),
        .vec_out(vec0), .dut_in(din0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_err_vec(fvec0), .first_err_valid(fval0)
    );

    truth_table_sweeper #(
        .N_IN(3), .M_CH(1), .HOLD(1), .EXPECTED(8'h80)
    ) u_dut4 (
        .clk(clk), .reset(reset), .start(start4),
        .vec_out(vec4), .dut_in(1'b1),
        .busy(busy4), .done(done4), .pass(pass4),
        .err_count(err4), .first_err_vec(fvec4), .first_err_valid(fval4)
    );

    typedef struct {
        int err;
        int fvec;
        int fvalid;
        int pass;
        int busy_cycles;
    } exp_t;

    exp_t q0[$];
    exp_t q4[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected vector for ordinal k in the configured sweep order
    function automatic logic [4:0] seqv(input int k);
`ifdef SWEEP_GRAY_EN
        return 5'(k ^ (k >> 1));
`else
        return 5'(k);
`endif
    endfunction

    // ---------------- monitor / scoreboard ----------------
    int bcnt0 = 0;
    int bcnt4 = 0;
    bit pdone0 = 1'b0;
    bit pdone4 = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            bcnt0 = 0;
            bcnt4 = 0;
        end else begin
            if (busy0) begin
                check("vec_seq0", 32'(vec0), 32'(seqv(bcnt0 / 10)));
                bcnt0++;
            end
            if (busy4) begin
                check("vec_seq4", 32'(vec4), 32'(3'(seqv(bcnt4))));
                bcnt4++;
            end
            if (done0 && !pdone0) begin
                if (q0.size() == 0) begin
                    check("unexpected_done0", 32'(1), 32'(0));
                end else begin
                    e = q0.pop_front();
                    check("busy_cycles0", 32'(bcnt0), 32'(e.busy_cycles));
                    check("err_count0", 32'(err0), 32'(e.err));
                    check("first_err_vec0", 32'(fvec0), 32'(e.fvec));
                    check("first_err_valid0", 32'(fval0), 32'(e.fvalid));
                    check("pass0", 32'(pass0), 32'(e.pass));
                    check("busy_in_done0", 32'(busy0), 32'(0));
                    check("vec_hold_done0", 32'(vec0), 32'(seqv(31)));
                end
                bcnt0 = 0;
            end
            if (done4 && !pdone4) begin
                if (q4.size() == 0) begin
                    check("unexpected_done4", 32'(1), 32'(0));
                end else begin
                    e = q4.pop_front();
                    check("busy_cycles4", 32'(bcnt4), 32'(e.busy_cycles));
                    check("err_count4", 32'(err4), 32'(e.err));
                    check("first_err_vec4", 32'(fvec4), 32'(e.fvec));
                    check("first_err_valid4", 32'(fval4), 32'(e.fvalid));
                    check("pass4", 32'(pass4), 32'(e.pass));
                    check("vec_hold_done4", 32'(vec4), 32'(3'(seqv(7))));
                end
                bcnt4 = 0;
            end
        end
        pdone0 = done0;
        pdone4 = done4;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done0();
        int n;
        n = 0;
        while (!done0 && n < 2000) begin
            tick();
            n++;
        end
        if (!done0) check("timeout_done0", 32'(0), 32'(1));
        tick();
    endtask

    task automatic wait_done4();
        int n;
        n = 0;
        while (!done4 && n < 200) begin
            tick();
            n++;
        end
        if (!done4) check("timeout_done4", 32'(0), 32'(1));
        tick();
    endtask

    task automatic push0(input int err, input int fvec, input int fvalid, input int pass);
        exp_t e;
        e.err = err; e.fvec = fvec; e.fvalid = fvalid; e.pass = pass; e.busy_cycles = 320;
        q0.push_back(e);
    endtask

    initial begin
        exp_t e4;
        int n;
        reset  = 1'b1;
        start0 = 1'b0;
        start4 = 1'b0;
        stuck  = 1'b0;

        // T1: reset for two cycles
        tick();
        tick();
        check("rst_busy0", 32'(busy0), 32'(0));
        check("rst_done0", 32'(done0), 32'(0));
        check("rst_pass0", 32'(pass0), 32'(0));
        check("rst_err0", 32'(err0), 32'(0));
        check("rst_fvec0", 32'(fvec0), 32'(0));
        check("rst_fval0", 32'(fval0), 32'(0));
        check("rst_vec0", 32'(vec0), 32'(0));
        check("rst_busy4", 32'(busy4), 32'(0));
        check("rst_done4", 32'(done4), 32'(0));
        check("rst_err4", 32'(err4), 32'(0));
        reset = 1'b0;
        tick();

        // T2: good DUT, start from IDLE
        push0(0, 0, 0, 1);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("busy_after_start", 32'(busy0), 32'(1));
        wait_done0();

        // T3: ch1 stuck at 0, restart from DONE
        stuck = 1'b1;
        push0(31, 1, 1, 0);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("restart_err_cleared", 32'(err0), 32'(0));
        check("restart_done_low", 32'(done0), 32'(0));
        wait_done0();

        // Good DUT again from DONE, start held high for 50 cycles into RUN
        stuck = 1'b0;
        push0(0, 0, 0, 1);
        start0 = 1'b1;
        repeat (50) tick();
        start0 = 1'b0;
        wait_done0();

        // T4: HOLD=1 config, DUT constant 1
        e4.err = 7; e4.fvec = 0; e4.fvalid = 1; e4.pass = 0; e4.busy_cycles = 8;
        q4.push_back(e4);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        wait_done4();

        // T5: abort a failing sweep with reset around cycle 100
        stuck = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (99) tick();
        check("pre_abort_err_nonzero", 32'(err0 != 0), 32'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 32'(busy0), 32'(0));
        check("abort_done", 32'(done0), 32'(0));
        check("abort_err", 32'(err0), 32'(0));
        check("abort_fval", 32'(fval0), 32'(0));
        repeat (3) tick();
        stuck = 1'b0;
        push0(0, 0, 0, 1);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_done0();

        // Drain the scoreboard
        n = 0;
        while ((q0.size() != 0 || q4.size() != 0) && n < 20) begin
            tick();
            n++;
        end
        check("q0_drained", 32'(q0.size()), 32'(0));
        check("q4_drained", 32'(q4.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
